// File: rtl/mem_access.sv
// mem_access: memory-access stage sitting behind EX.
// Runs one data-bus transaction per load/store request, aligns and extends
// load data, and forwards ALU results with one cycle of latency.
// Optional build macro: MEM_TIMEOUT_EN adds a bus wait-cycle limit
// (TIMEOUT_CYC) that aborts a stuck transaction and pulses MEM_err.
module mem_access #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_x_rd_vld,
  input  logic [31:0] EX_x_rd,
  input  logic [31:0] EX_MEMaddr,
  input  logic [3:0]  EX_MEMrden,
  input  logic        EX_MEMrden_SEXT,
  input  logic [3:0]  EX_MEMwren,
  input  logic [31:0] EX_MEMwrdata,
  output logic        MEM_busy,
  output logic        MEM_x_rd_vld,
  output logic [31:0] MEM_x_rd,
  output logic        MEM_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUS = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  lane_q, lane_d;
  logic        sext_q, sext_d;
  logic        busy_q, busy_d;
  logic        rd_vld_q, rd_vld_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Pick the addressed byte/half/word out of the bus word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [3:0]  be,
                                               input logic [1:0]  lane,
                                               input logic        sext);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half_v = 16'h0000;
    byte_v = 8'h00;
    res    = 32'h0000_0000;
    case (be)
      4'b1111: res = rdata;
      4'b0011: begin
        half_v = rdata[15:0];
        res    = {{16{sext & half_v[15]}}, half_v};
      end
      4'b1100: begin
        half_v = rdata[31:16];
        res    = {{16{sext & half_v[15]}}, half_v};
      end
      default: begin
        case (lane)
          2'd0:    byte_v = rdata[7:0];
          2'd1:    byte_v = rdata[15:8];
          2'd2:    byte_v = rdata[23:16];
          default: byte_v = rdata[31:24];
        endcase
        res = {{24{sext & byte_v[7]}}, byte_v};
      end
    endcase
    return res;
  endfunction

  // Next-state and next-output logic for the IDLE/BUS sequencer.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    lane_d   = lane_q;
    sext_d   = sext_q;
    busy_d   = busy_q;
    rd_vld_d = 1'b0;
    rd_d     = rd_q;
    err_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if ((|EX_MEMwren) || (|EX_MEMrden)) begin
          // A store wins if both enables are set.
          if (|EX_MEMwren) begin
            we_d = 1'b1;
            be_d = EX_MEMwren;
          end else begin
            we_d = 1'b0;
            be_d = EX_MEMrden;
          end
          addr_d  = {EX_MEMaddr[31:2], 2'b00};
          wdata_d = EX_MEMwrdata << {EX_MEMaddr[1:0], 3'b000};
          lane_d  = EX_MEMaddr[1:0];
          sext_d  = EX_MEMrden_SEXT;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = BUS;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (EX_x_rd_vld) begin
          rd_vld_d = 1'b1;
          rd_d     = EX_x_rd;
        end else begin
          rd_vld_d = 1'b0;
        end
      end
      BUS: begin
        if (dbus_ack) begin
          req_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (!we_q) begin
            rd_vld_d = 1'b1;
            rd_d     = load_extract(dbus_rdata, be_q, lane_q, sext_q);
          end else begin
            rd_vld_d = 1'b0;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == TO_LIM) begin
          req_d   = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
          if (!we_q) begin
            rd_vld_d = 1'b1;
            rd_d     = 32'h0000_0000;
          end else begin
            rd_vld_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
`else
        end else begin
          req_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0000_0000;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0000_0000;
      lane_q   <= 2'b00;
      sext_q   <= 1'b0;
      busy_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_q     <= 32'h0000_0000;
      err_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      lane_q   <= lane_d;
      sext_q   <= sext_d;
      busy_q   <= busy_d;
      rd_vld_q <= rd_vld_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign MEM_busy     = busy_q;
  assign MEM_x_rd_vld = rd_vld_q;
  assign MEM_x_rd     = rd_q;
  assign MEM_err      = err_q;
  assign dbus_req     = req_q;
  assign dbus_we      = we_q;
  assign dbus_addr    = addr_q;
  assign dbus_be      = be_q;
  assign dbus_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected write-backs,
// a negedge monitor pops and compares them whenever MEM_x_rd_vld is high.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EX_x_rd_vld;
  logic [31:0] EX_x_rd;
  logic [31:0] EX_MEMaddr;
  logic [3:0]  EX_MEMrden;
  logic        EX_MEMrden_SEXT;
  logic [3:0]  EX_MEMwren;
  logic [31:0] EX_MEMwrdata;
  logic        MEM_busy, MEM_x_rd_vld, MEM_err;
  logic [31:0] MEM_x_rd;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_exp_cyc = -1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  mem_access #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_x_rd_vld(EX_x_rd_vld), .EX_x_rd(EX_x_rd),
    .EX_MEMaddr(EX_MEMaddr), .EX_MEMrden(EX_MEMrden),
    .EX_MEMrden_SEXT(EX_MEMrden_SEXT), .EX_MEMwren(EX_MEMwren),
    .EX_MEMwrdata(EX_MEMwrdata),
    .MEM_busy(MEM_busy), .MEM_x_rd_vld(MEM_x_rd_vld), .MEM_x_rd(MEM_x_rd),
    .MEM_err(MEM_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Cycle counter used to check latencies.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compare every write-back and error pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && MEM_x_rd_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rd_vld", MEM_x_rd, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("wb_data", MEM_x_rd, e.data);
        chk("wb_cycle", cyc, e.cyc);
      end
    end
    if (rst_n === 1'b1 && MEM_err !== 1'b0) begin
      chk("mem_err_cycle", cyc, err_exp_cyc);
    end
  end

  // Watchdog: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic sb_push(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  task automatic clear_ex();
    EX_x_rd_vld = 1'b0; EX_x_rd = 32'h0; EX_MEMaddr = 32'h0;
    EX_MEMrden = 4'b0000; EX_MEMrden_SEXT = 1'b0;
    EX_MEMwren = 4'b0000; EX_MEMwrdata = 32'h0;
  endtask

  // Present one EX-stage request for exactly one clock edge.
  task automatic issue(input logic vld, input logic [31:0] xrd, input logic [31:0] addr,
                       input logic [3:0] rden, input logic sext, input logic [3:0] wren,
                       input logic [31:0] wdata);
    EX_x_rd_vld = vld; EX_x_rd = xrd; EX_MEMaddr = addr;
    EX_MEMrden = rden; EX_MEMrden_SEXT = sext;
    EX_MEMwren = wren; EX_MEMwrdata = wdata;
    @(posedge clk); #1;
    clear_ex();
  endtask

  // Bus responder: check the request, wait, ack, and count busy cycles.
  task automatic bus_xfer(input int waits, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic e_we, input logic [31:0] e_wdata, input int e_busy);
    int busy_cyc = 0;
    int guard = 0;
    while (dbus_req !== 1'b1 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    chk("dbus_req_seen", {31'h0, dbus_req}, 32'h1);
    chk("dbus_addr", dbus_addr, e_addr);
    chk("dbus_be", {28'h0, dbus_be}, {28'h0, e_be});
    chk("dbus_we", {31'h0, dbus_we}, {31'h0, e_we});
    if (e_we) chk("dbus_wdata", dbus_wdata, e_wdata);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk); if (MEM_busy) busy_cyc++;
      @(posedge clk); #1;
    end
    dbus_ack = 1'b1; dbus_rdata = rdata;
    @(negedge clk); if (MEM_busy) busy_cyc++;
    chk("dbus_addr_held", dbus_addr, e_addr);
    chk("dbus_req_held", {31'h0, dbus_req}, 32'h1);
    @(posedge clk); #1;
    dbus_ack = 1'b0; dbus_rdata = 32'hDEAD_BEEF;
    @(negedge clk); if (MEM_busy) busy_cyc++;
    chk("busy_cycles", busy_cyc, e_busy);
    chk("dbus_req_drop", {31'h0, dbus_req}, 32'h0);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [3:0] rden, input logic sext,
                         input int waits, input logic [31:0] rdata, input logic [31:0] exp);
    sb_push(exp, cyc + 2 + waits);
    issue(1'b1, 32'h0, addr, rden, sext, 4'b0000, 32'h0);
    bus_xfer(waits, rdata, {addr[31:2], 2'b00}, rden, 1'b0, 32'h0, waits + 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    clear_ex();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'h0, MEM_busy}, 32'h0);
    chk("rst_rd_vld", {31'h0, MEM_x_rd_vld}, 32'h0);
    chk("rst_req", {31'h0, dbus_req}, 32'h0);
    chk("rst_err", {31'h0, MEM_err}, 32'h0);
    chk("rst_addr", dbus_addr, 32'h0);
    chk("rst_rd", MEM_x_rd, 32'h0);
    @(posedge clk); #1;

    // ALU pass-through, one cycle latency, no bus activity.
    sb_push(32'h1234_5678, cyc + 1);
    issue(1'b1, 32'h1234_5678, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0);
    @(negedge clk);
    chk("alu_no_req", {31'h0, dbus_req}, 32'h0);
    @(posedge clk); #1;

    // Word load, ack on first BUS cycle, then a back-to-back ALU op
    // presented in the cycle MEM_busy falls.
    sb_push(32'hCAFE_BABE, cyc + 2);
    issue(1'b1, 32'h0, 32'h0000_0100, 4'b1111, 1'b0, 4'b0000, 32'h0);
    bus_xfer(0, 32'hCAFE_BABE, 32'h0000_0100, 4'b1111, 1'b0, 32'h0, 1);
    sb_push(32'h0BAD_F00D, cyc + 1);
    issue(1'b1, 32'h0BAD_F00D, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0);
    @(posedge clk); #1;

    // Byte and half loads with sign/zero extension.
    do_load(32'h0000_0103, 4'b1000, 1'b1, 0, 32'h8011_2233, 32'hFFFF_FF80);
    do_load(32'h0000_0103, 4'b1000, 1'b0, 0, 32'h8011_2233, 32'h0000_0080);
    do_load(32'h0000_0102, 4'b1100, 1'b1, 1, 32'h9ABC_0000, 32'hFFFF_9ABC);
    do_load(32'h0000_0100, 4'b0011, 1'b0, 2, 32'h1234_F00D, 32'h0000_F00D);
    do_load(32'h0000_0101, 4'b0010, 1'b1, 0, 32'h0000_7F00, 32'h0000_007F);

    // Word store with five wait cycles: six busy cycles, no write-back.
    issue(1'b0, 32'h0, 32'h0000_0200, 4'b0000, 1'b0, 4'b1111, 32'hAABB_CCDD);
    bus_xfer(5, 32'h0, 32'h0000_0200, 4'b1111, 1'b1, 32'hAABB_CCDD, 6);
    chk("rd_hold_after_store", MEM_x_rd, 32'h0000_007F);
    @(posedge clk); #1;

    // Byte store at lane 1: data shifted into bits [15:8].
    issue(1'b0, 32'h0, 32'h0000_0201, 4'b0000, 1'b0, 4'b0010, 32'h0000_00AB);
    bus_xfer(0, 32'h0, 32'h0000_0200, 4'b0010, 1'b1, 32'h0000_AB00, 1);
    @(posedge clk); #1;

    // Both enables set: handled as a store, no write-back.
    issue(1'b1, 32'h0, 32'h0000_0300, 4'b1111, 1'b0, 4'b0001, 32'h0000_0055);
    bus_xfer(0, 32'hFFFF_FFFF, 32'h0000_0300, 4'b0001, 1'b1, 32'h0000_0055, 1);
    @(posedge clk); #1;

    // Ack while idle must be ignored.
    dbus_ack = 1'b1; dbus_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_no_req", {31'h0, dbus_req}, 32'h0);
    @(posedge clk); #1;

    // Reset mid-transaction; EX input ignored while busy.
    issue(1'b1, 32'h0, 32'h0000_0400, 4'b1111, 1'b0, 4'b0000, 32'h0);
    issue(1'b1, 32'h0000_0077, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0);
    @(negedge clk);
    chk("pre_rst_req", {31'h0, dbus_req}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'h0, dbus_req}, 32'h0);
    chk("post_rst_busy", {31'h0, MEM_busy}, 32'h0);
    @(posedge clk); #1;
    do_load(32'h0000_0100, 4'b1111, 1'b0, 0, 32'h5566_7788, 32'h5566_7788);

`ifdef MEM_TIMEOUT_EN
    // Load never acked: abort after the limit with rd=0 and an error pulse.
    sb_push(32'h0000_0000, cyc + 6);
    err_exp_cyc = cyc + 6;
    issue(1'b1, 32'h0, 32'h0000_0500, 4'b1111, 1'b0, 4'b0000, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk("timeout_req_drop", {31'h0, dbus_req}, 32'h0);
    chk("timeout_busy_drop", {31'h0, MEM_busy}, 32'h0);
    @(posedge clk); #1;
    err_exp_cyc = -1;
    // Ack in the same cycle as the limit: normal completion, no error.
    do_load(32'h0000_0500, 4'b1111, 1'b0, 4, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
